// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: starts a thread on an entry-point trigger and streams sequential
// instructions from a synchronous ROM to the decoder through a 2-entry buffer.
module instruction_fetch_unit #(
  parameter int unsigned ROM_ADDRESS_WIDTH = 16,
  parameter int unsigned INSTRUCTION_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH        = 2
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         iTrigger,
  input  logic [ROM_ADDRESS_WIDTH-1:0] iEntryPoint,
  input  logic [INSTRUCTION_WIDTH-1:0] iIMemData,
  input  logic                         iDecodeReady,
  input  logic                         iBranchTaken,
  input  logic [ROM_ADDRESS_WIDTH-1:0] iBranchTarget,
  input  logic                         iHalt,
  output logic                         oIMemRead,
  output logic [ROM_ADDRESS_WIDTH-1:0] oIMemAddr,
  output logic [INSTRUCTION_WIDTH-1:0] oInstruction,
  output logic [ROM_ADDRESS_WIDTH-1:0] oInstructionPC,
  output logic                         oInstructionValid,
  output logic                         oIFU_Busy
);

  localparam int unsigned AW    = ROM_ADDRESS_WIDTH;
  localparam int unsigned IW    = INSTRUCTION_WIDTH;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] data;
  } entry_t;

  state_t           state;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    pc_pipe;
  logic             inflight;
  logic             drop;
  logic [CNT_W-1:0] count;
  entry_t           fifo0;
  entry_t           fifo1;

  logic   running;
  logic   halt_c;
  logic   branch_c;
  logic   flush;
  logic   pop;
  logic   push;
  logic   rd;
  entry_t new_entry;

  // Read issue keeps buffered + in-flight words within the two buffer slots.
  always_comb begin
    running   = (state == RUN);
    halt_c    = running & iHalt;
    branch_c  = running & iBranchTaken & ~iHalt;
    flush     = halt_c | branch_c;
    pop       = oInstructionValid & iDecodeReady;
    push      = inflight & ~drop & ~flush;
    rd        = running & ~flush &
                (({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop)));
    new_entry = '{pc: pc_pipe, data: iIMemData};
  end

  assign oIMemRead         = rd;
  assign oIMemAddr         = rd ? pc : '0;
  assign oInstruction      = fifo0.data;
  assign oInstructionPC    = fifo0.pc;
  assign oInstructionValid = (count != '0);
  assign oIFU_Busy         = running;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      pc       <= '0;
      pc_pipe  <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      count    <= '0;
      fifo0    <= '0;
      fifo1    <= '0;
    end else begin
      inflight <= rd;
      drop     <= flush & inflight;
      if (rd) begin
        pc_pipe <= pc;
        pc      <= pc + AW'(1);
      end

      case (state)
        IDLE: begin
          if (iTrigger) begin
            state <= RUN;
            pc    <= iEntryPoint;
          end
        end
        RUN: begin
          if (iHalt) state <= IDLE;
          else if (iBranchTaken) pc <= iBranchTarget;
        end
        default: state <= IDLE;
      endcase

      // Shift-register buffer: fifo0 is always the head.
      if (flush) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b01: begin
            fifo0 <= fifo1;
            count <= count - CNT_W'(1);
          end
          2'b10: begin
            if (count == '0) fifo0 <= new_entry;
            else             fifo1 <= new_entry;
            count <= count + CNT_W'(1);
          end
          2'b11: begin
            if (count == CNT_W'(FIFO_DEPTH)) begin
              fifo0 <= fifo1;
              fifo1 <= new_entry;
            end else begin
              fifo0 <= new_entry;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cycle table plus stall, wrap and reset sequences.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iTrigger;
  logic [15:0] iEntryPoint;
  logic [63:0] iIMemData;
  logic        iDecodeReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        iHalt;
  logic        oIMemRead;
  logic [15:0] oIMemAddr;
  logic [63:0] oInstruction;
  logic [15:0] oInstructionPC;
  logic        oInstructionValid;
  logic        oIFU_Busy;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .iTrigger(iTrigger), .iEntryPoint(iEntryPoint),
    .iIMemData(iIMemData), .iDecodeReady(iDecodeReady), .iBranchTaken(iBranchTaken),
    .iBranchTarget(iBranchTarget), .iHalt(iHalt), .oIMemRead(oIMemRead),
    .oIMemAddr(oIMemAddr), .oInstruction(oInstruction), .oInstructionPC(oInstructionPC),
    .oInstructionValid(oInstructionValid), .oIFU_Busy(oIFU_Busy)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM model: word = 0xA5 in the top byte, address in the low bits.
  always @(posedge Clock) if (oIMemRead) iIMemData <= {8'hA5, 40'h0, oIMemAddr};

  function automatic logic [63:0] word_of(input logic [15:0] a);
    return {8'hA5, 40'h0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        trig;
    logic [15:0] entry;
    logic        rdy;
    logic        br;
    logic [15:0] tgt;
    logic        halt;
    logic        e_busy;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs [23];

  // Stream monitor state for the hand-written sequences.
  logic [15:0] exp_pc;
  int          issued, accepted;
  logic [15:0] read_log [8];
  int          nreads;

  task automatic idle_inputs();
    iTrigger = 0; iEntryPoint = 0; iBranchTaken = 0; iBranchTarget = 0; iHalt = 0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 0;
    idle_inputs();
    iDecodeReady = 1;
    @(negedge Clock);
    Reset = 1;
  endtask

  task automatic trigger(input logic [15:0] ep);
    @(negedge Clock);
    iTrigger = 1; iEntryPoint = ep;
    @(negedge Clock);
    iTrigger = 0;
  endtask

  // One cycle with the given ready; checks ordering and outstanding bound.
  task automatic step(input logic r);
    if (r !== iDecodeReady || 1'b1) iDecodeReady = r;
    #1;
    chk("outstanding_le_2", 64'((issued - accepted) <= 2), 64'd1);
    if (oIMemRead) begin
      issued++;
      if (nreads < 8) read_log[nreads] = oIMemAddr;
      nreads++;
    end
    if (oInstructionValid && iDecodeReady) begin
      chk("stream_pc", 64'(oInstructionPC), 64'(exp_pc));
      chk("stream_data", oInstruction, word_of(exp_pc));
      exp_pc = exp_pc + 16'd1;
      accepted++;
    end
    @(negedge Clock);
  endtask

  task automatic start_stream(input logic [15:0] ep, input logic r);
    do_reset();
    iDecodeReady = r;
    iTrigger = 1; iEntryPoint = ep;
    exp_pc = ep; issued = 0; accepted = 0; nreads = 0;
    @(negedge Clock);
    iTrigger = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held_pc;
    logic [63:0] held_data;

    vecs[0]  = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0041, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b1, 16'h0040};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0043, 1'b1, 16'h0041};
    vecs[5]  = '{1'b1, 16'h0500, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0044, 1'b1, 16'h0042};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0045, 1'b1, 16'h0043};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0046, 1'b1, 16'h0044};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0045};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b1, 16'h0100};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0103, 1'b1, 16'h0101};
    vecs[13] = '{1'b1, 16'h0600, 1'b1, 1'b1, 16'h0300, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0102};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[16] = '{1'b1, 16'h0200, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0201, 1'b0, 16'h0000};
    vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0202, 1'b1, 16'h0200};
    vecs[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0203, 1'b1, 16'h0201};
    vecs[21] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0202};
    vecs[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};

    Reset = 0;
    idle_inputs();
    iDecodeReady = 1;
    iIMemData = '0;
    @(negedge Clock);
    @(negedge Clock);
    #1;
    chk("rst_busy", 64'(oIFU_Busy), 64'd0);
    chk("rst_read", 64'(oIMemRead), 64'd0);
    chk("rst_addr", 64'(oIMemAddr), 64'd0);
    chk("rst_valid", 64'(oInstructionValid), 64'd0);
    chk("rst_instr", oInstruction, 64'd0);
    chk("rst_pc", 64'(oInstructionPC), 64'd0);
    @(negedge Clock);
    Reset = 1;

    // Cycle table: start, trigger-in-RUN, branch, halt+branch+trigger, retrigger, halt.
    for (int i = 0; i < 23; i++) begin
      @(negedge Clock);
      iTrigger      = vecs[i].trig;
      iEntryPoint   = vecs[i].entry;
      iDecodeReady  = vecs[i].rdy;
      iBranchTaken  = vecs[i].br;
      iBranchTarget = vecs[i].tgt;
      iHalt         = vecs[i].halt;
      #1;
      chk($sformatf("v%0d_busy", i), 64'(oIFU_Busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_read", i), 64'(oIMemRead), 64'(vecs[i].e_read));
      chk($sformatf("v%0d_valid", i), 64'(oInstructionValid), 64'(vecs[i].e_valid));
      if (vecs[i].e_read) chk($sformatf("v%0d_addr", i), 64'(oIMemAddr), 64'(vecs[i].e_addr));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), 64'(oInstructionPC), 64'(vecs[i].e_pc));
        chk($sformatf("v%0d_data", i), oInstruction, word_of(vecs[i].e_pc));
      end
    end
    idle_inputs();

    // Mid-stream stall of 5 cycles: head held, no skip/dup on resume.
    start_stream(16'h0040, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1);
    #1;
    held_pc = oInstructionPC;
    held_data = oInstruction;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      chk("stall_valid", 64'(oInstructionValid), 64'd1);
      chk("stall_pc", 64'(oInstructionPC), 64'(held_pc));
      chk("stall_data", oInstruction, held_data);
      if (i > 0) chk("stall_no_read", 64'(oIMemRead), 64'd0);
    end
    for (int i = 0; i < 8; i++) step(1'b1);
    chk("stall_accepted", 64'(accepted), 64'd12);

    // Decoder never ready: exactly two reads, 0x40 and 0x41.
    start_stream(16'h0040, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("noready_nreads", 64'(nreads), 64'd2);
    chk("noready_rd0", 64'(read_log[0]), 64'h0040);
    chk("noready_rd1", 64'(read_log[1]), 64'h0041);
    chk("noready_valid", 64'(oInstructionValid), 64'd1);
    chk("noready_head", 64'(oInstructionPC), 64'h0040);

    // PC wrap: 0xFFFE, 0xFFFF, 0x0000, ...
    start_stream(16'hFFFE, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1);
    chk("wrap_accepted", 64'(accepted), 64'd5);
    chk("wrap_next_pc", 64'(exp_pc), 64'h0003);

    // Asynchronous reset mid-stream clears every output at once.
    start_stream(16'h0040, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1);
    #1;
    Reset = 0;
    #1;
    chk("arst_busy", 64'(oIFU_Busy), 64'd0);
    chk("arst_read", 64'(oIMemRead), 64'd0);
    chk("arst_addr", 64'(oIMemAddr), 64'd0);
    chk("arst_valid", 64'(oInstructionValid), 64'd0);
    chk("arst_instr", oInstruction, 64'd0);
    chk("arst_pc", 64'(oInstructionPC), 64'd0);
    @(negedge Clock);
    Reset = 1;
    @(negedge Clock);
    #1;
    chk("post_rst_busy", 64'(oIFU_Busy), 64'd0);
    chk("post_rst_valid", 64'(oInstructionValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
